main_bus_rr_arbiter: RTL and testbench
======================================

// Module: main_bus_rr_arbiter
// PURPOSE
//  Round-robin arbiter and transfer sequencer for the shared 16-bit main bus (clk100 domain).
//  Grants one master (USB interface, future DAQ/CPU masters) at a time and drives target_ready to the address decoder.
//  Waits for address_valid (OR of registered dev_sel), issues data_strobe, then releases the bus.
//  Flags slaves that never decode (timeout) via error_o; feeds the error LED.
// PARAMETERS
//  NUM_MASTERS      4   number of requesters; barq/bagd width
//  CLK_MAX_TIMEOUT  12  GRANT cycles allowed before address_valid must be seen
//  STROBE_CYCLES    1   data_strobe width in cycles (1..15)
// PORTS
//  clk              in   1            bus clock (clk100); single clock domain
//  reset            in   1            asynchronous, active-high reset
//  barq_i           in   NUM_MASTERS  bus access request, level, held by master until it sees the transfer end
//  bagd_o           out  NUM_MASTERS  one-hot grant; selects master address/rw/data onto bus
//  grant_idx_o      out  $clog2(NUM_MASTERS)  index of current/last owner
//  target_ready_o   out  1            enables decoder dev_sel register (low = async clear of dev_sel)
//  address_valid_i  in   1            some slave decoded the address (registered, 1 cycle after target_ready)
//  data_strobe_o    out  1            write/read-capture strobe to selected slave and owner
//  busy_o           out  1            state != IDLE
//  error_o          out  1            one-cycle pulse on decode timeout
// BEHAVIOUR
//  All outputs registered; reset -> state IDLE, bagd_o=0, grant_idx_o=0, target_ready_o=0, data_strobe_o=0, error_o=0, RR pointer=0.
//  States: IDLE, GRANT, STROBE, RELEASE, ERROR (arb_state_t).
//  IDLE: if |barq_i, pick first requester at/after RR pointer (wrap mod NUM_MASTERS); next cycle bagd_o one-hot,
//   target_ready_o=1, timeout cnt=0 -> GRANT. No request -> stay, outputs 0.
//  GRANT: address_valid_i sampled 1 -> STROBE (strobe asserted next cycle). Owner drops barq -> IDLE (abort,
//   no strobe, no error). Else cnt++; cnt==CLK_MAX_TIMEOUT-1 without valid -> ERROR. Abort beats valid when simultaneous.
//  STROBE: data_strobe_o=1 for exactly STROBE_CYCLES cycles, bagd/target_ready held; then -> RELEASE.
//   address_valid_i dropping during STROBE ignored (strobe completes).
//  RELEASE: target_ready_o=0 (clears dev_sel), data_strobe_o=0, bagd_o held until owner barq low -> IDLE.
//  ERROR: error_o=1 one cycle, bagd_o=0, target_ready_o=0 -> IDLE. Owner may re-request; it is queued normally.
//  RR pointer = owner+1 (wrap) on every exit to IDLE (complete, abort, error) -> no starvation.
//  Bus turnaround: at least one IDLE cycle with bagd_o=0 between consecutive grants.
//  Minimum transfer: grant cycle, 1+ GRANT cycle, STROBE_CYCLES, 1 RELEASE cycle.
//  Non-owner barq changes never affect an ongoing transfer. Reset mid-transfer: all outputs drop immediately.
//  Timeout counter width $clog2(CLK_MAX_TIMEOUT+1); strobe counter 4 bits; no wrap reachable.
// CONFIGURATION
//  ARB_ERR_CNT_EN defined: adds ports err_cnt_o (out, 8) saturating count of timeouts (stays 255),
//   err_clr_i (in, 1) synchronous clear; clear wins over simultaneous increment; reset value 0.
//  Not defined: ports absent, error_o pulse only; all other behaviour identical.
// STRUCTURE
//  Skeleton_package: NUM_MASTERS, arb_state_t enum, ARB_TIMEOUT_DEFAULT constant.
//  Sub-module rr_priority_picker: combinational (req, pointer) -> one-hot grant + index; FSM/counters in top.
// TESTING
//  1 Reset, barq=0001, address_valid 1 cycle after target_ready -> bagd=0001, one 1-cycle data_strobe, release when barq drops.
//  2 barq=1111 held, each completes -> grant order 0,1,2,3,0; >=1 idle cycle with bagd=0 between grants.
//  3 barq=0100, address_valid never -> error_o pulse exactly 12 cycles after target_ready rises; bagd=0; no strobe.
//  4 Owner drops barq in GRANT (same cycle address_valid rises) -> IDLE, no strobe, no error, pointer advanced.
//  5 Reset asserted mid-STROBE -> all outputs 0 same cycle; resume from IDLE, pointer 0.
//  6 ARB_ERR_CNT_EN: 300 timeouts -> err_cnt_o=255; err_clr_i with timeout same cycle -> 0.

Source files
------------

// File: rtl/main_bus_rr_arbiter_pkg.sv
// main_bus_rr_arbiter_pkg: shared constants and state type for the main bus arbiter
package main_bus_rr_arbiter_pkg;

    localparam int NUM_MASTERS         = 4;
    localparam int ARB_TIMEOUT_DEFAULT = 12;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        STROBE,
        RELEASE,
        ERROR
    } arb_state_t;

    // Successor of a master index, wrapping at n.
    function automatic int next_index(int idx, int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational round-robin pick of the first requester at/after ptr
module rr_priority_picker
    import main_bus_rr_arbiter_pkg::*;
#(
    parameter int N  = NUM_MASTERS,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic found;
    int   k;

    // Walk requesters starting at ptr with wrap and take the first one that is set.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!found && req[k]) begin
                found  = 1'b1;
                gnt[k] = 1'b1;
                idx    = IW'(k);
            end
        end
    end

endmodule

// File: rtl/main_bus_rr_arbiter.sv
// main_bus_rr_arbiter: round-robin bus arbiter and transfer sequencer; ARB_ERR_CNT_EN adds a timeout counter
module main_bus_rr_arbiter #(
    parameter int NUM_MASTERS     = main_bus_rr_arbiter_pkg::NUM_MASTERS,
    parameter int CLK_MAX_TIMEOUT = main_bus_rr_arbiter_pkg::ARB_TIMEOUT_DEFAULT,
    parameter int STROBE_CYCLES   = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_MASTERS-1:0]         barq_i,
    output logic [NUM_MASTERS-1:0]         bagd_o,
    output logic [$clog2(NUM_MASTERS)-1:0] grant_idx_o,
    output logic                           target_ready_o,
    input  logic                           address_valid_i,
    output logic                           data_strobe_o,
    output logic                           busy_o,
`ifdef ARB_ERR_CNT_EN
    output logic [7:0]                     err_cnt_o,
    input  logic                           err_clr_i,
`endif
    output logic                           error_o
);

    import main_bus_rr_arbiter_pkg::*;

    localparam int IW = $clog2(NUM_MASTERS);
    localparam int TW = $clog2(CLK_MAX_TIMEOUT + 1);

    arb_state_t           state, state_nxt;
    logic [NUM_MASTERS-1:0] pick_gnt, bagd_nxt;
    logic [IW-1:0]        pick_idx, idx_nxt, ptr, ptr_nxt, adv_ptr;
    logic [TW-1:0]        cnt, cnt_nxt;
    logic [3:0]           scnt, scnt_nxt;
    logic                 tr_nxt, ds_nxt, err_nxt, own_req;

    assign own_req = barq_i[grant_idx_o];
    assign adv_ptr = IW'(next_index(int'(grant_idx_o), NUM_MASTERS));

    rr_priority_picker #(
        .N  (NUM_MASTERS),
        .IW (IW)
    ) u_picker (
        .req (barq_i),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    // Next state and next registered outputs; owner abort is tested before decode and timeout.
    always_comb begin
        state_nxt = state;
        bagd_nxt  = bagd_o;
        idx_nxt   = grant_idx_o;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        scnt_nxt  = scnt;
        tr_nxt    = target_ready_o;
        ds_nxt    = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (|barq_i) begin
                    state_nxt = GRANT;
                    bagd_nxt  = pick_gnt;
                    idx_nxt   = pick_idx;
                    tr_nxt    = 1'b1;
                    cnt_nxt   = '0;
                end
            end
            GRANT: begin
                if (!own_req) begin
                    state_nxt = IDLE;
                    bagd_nxt  = '0;
                    tr_nxt    = 1'b0;
                    ptr_nxt   = adv_ptr;
                end else if (address_valid_i) begin
                    state_nxt = STROBE;
                    ds_nxt    = 1'b1;
                    scnt_nxt  = '0;
                end else if (cnt == TW'(CLK_MAX_TIMEOUT - 1)) begin
                    state_nxt = ERROR;
                    err_nxt   = 1'b1;
                    bagd_nxt  = '0;
                    tr_nxt    = 1'b0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            STROBE: begin
                if (scnt == 4'(STROBE_CYCLES - 1)) begin
                    state_nxt = RELEASE;
                    tr_nxt    = 1'b0;
                end else begin
                    ds_nxt   = 1'b1;
                    scnt_nxt = scnt + 1'b1;
                end
            end
            RELEASE: begin
                if (!own_req) begin
                    state_nxt = IDLE;
                    bagd_nxt  = '0;
                    ptr_nxt   = adv_ptr;
                end
            end
            ERROR: begin
                state_nxt = IDLE;
                ptr_nxt   = adv_ptr;
            end
            default: begin
                state_nxt = IDLE;
                bagd_nxt  = '0;
                tr_nxt    = 1'b0;
            end
        endcase
    end

    // State, counters and all outputs are registered; reset drops outputs immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            bagd_o         <= '0;
            grant_idx_o    <= '0;
            ptr            <= '0;
            cnt            <= '0;
            scnt           <= '0;
            target_ready_o <= 1'b0;
            data_strobe_o  <= 1'b0;
            busy_o         <= 1'b0;
            error_o        <= 1'b0;
        end else begin
            state          <= state_nxt;
            bagd_o         <= bagd_nxt;
            grant_idx_o    <= idx_nxt;
            ptr            <= ptr_nxt;
            cnt            <= cnt_nxt;
            scnt           <= scnt_nxt;
            target_ready_o <= tr_nxt;
            data_strobe_o  <= ds_nxt;
            busy_o         <= state_nxt != IDLE;
            error_o        <= err_nxt;
        end
    end

`ifdef ARB_ERR_CNT_EN
    // Saturating timeout count; a clear overrides an increment in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_cnt_o <= '0;
        else
            err_cnt_o <= err_clr_i ? '0 : (err_nxt && !(&err_cnt_o)) ? err_cnt_o + 8'd1 : err_cnt_o;
    end
`endif

endmodule

// File: tb/tb_main_bus_rr_arbiter.sv
// tb_main_bus_rr_arbiter: directed self-checking bench for main_bus_rr_arbiter
module tb_main_bus_rr_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       av = 1'b0;
    logic [3:0] barq = 4'b0;
    logic [3:0] bagd;
    logic [1:0] gidx;
    logic       tr, ds, busy, err;
    logic [9:0] obs;
`ifdef ARB_ERR_CNT_EN
    logic [7:0] err_cnt;
    logic       err_clr = 1'b0;
`endif
    int n_cmp = 0;
    int n_err = 0;

    assign obs = {bagd, gidx, tr, ds, busy, err};

    always #5 clk = ~clk;

    main_bus_rr_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .barq_i          (barq),
        .bagd_o          (bagd),
        .grant_idx_o     (gidx),
        .target_ready_o  (tr),
        .address_valid_i (av),
        .data_strobe_o   (ds),
        .busy_o          (busy),
`ifdef ARB_ERR_CNT_EN
        .err_cnt_o       (err_cnt),
        .err_clr_i       (err_clr),
`endif
        .error_o         (err)
    );

    task automatic do_reset();
        barq  = 4'b0;
        av    = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        barq  = 4'b0;
        @(negedge clk);
        n_cmp++;
        if (obs !== 10'b0) begin
            n_err++;
            $display("FAIL reset_state: got %b expected %b", obs, 10'b0);
        end
`ifdef ARB_ERR_CNT_EN
        n_cmp++;
        if (err_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt);
        end
`endif
        reset = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        barq = 4'b0001;
        @(negedge clk);
        n_cmp++;
        if (obs !== {4'b0001, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL single_grant: got %b expected %b", obs, {4'b0001, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0});
        end
        av = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (obs !== {4'b0001, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL single_strobe: got %b expected %b", obs, {4'b0001, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0});
        end
        av = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (obs !== {4'b0001, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL single_release: got %b expected %b", obs, {4'b0001, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0});
        end
        @(negedge clk);
        n_cmp++;
        if (obs !== {4'b0001, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL single_hold_release: got %b expected %b", obs, {4'b0001, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0});
        end
        barq = 4'b0;
        @(negedge clk);
        n_cmp++;
        if (obs !== 10'b0) begin
            n_err++;
            $display("FAIL single_idle: got %b expected %b", obs, 10'b0);
        end
    endtask

    task automatic test_rr_order();
        int exp;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            exp = i % 4;
            n_cmp++;
            if ({bagd, busy} !== 5'b0) begin
                n_err++;
                $display("FAIL rr_turnaround_%0d: got %b expected %b", i, {bagd, busy}, 5'b0);
            end
            barq = 4'hf;
            @(negedge clk);
            n_cmp++;
            if ({bagd, gidx, tr} !== {4'(1 << exp), 2'(exp), 1'b1}) begin
                n_err++;
                $display("FAIL rr_grant_%0d: got %b expected %b", i, {bagd, gidx, tr}, {4'(1 << exp), 2'(exp), 1'b1});
            end
            av = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (ds !== 1'b1) begin
                n_err++;
                $display("FAIL rr_strobe_%0d: got %b expected 1", i, ds);
            end
            av = 1'b0;
            @(negedge clk);
            barq[exp] = 1'b0;
            @(negedge clk);
        end
        barq = 4'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        do_reset();
        barq = 4'b0100;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({bagd, tr, ds, err} !== {4'b0100, 1'b1, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL timeout_wait_%0d: got %b expected %b", c, {bagd, tr, ds, err}, {4'b0100, 1'b1, 1'b0, 1'b0});
            end
        end
        @(negedge clk);
        n_cmp++;
        if (obs !== {4'b0000, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL timeout_error: got %b expected %b", obs, {4'b0000, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1});
        end
        @(negedge clk);
        n_cmp++;
        if ({bagd, err, busy} !== 6'b0) begin
            n_err++;
            $display("FAIL timeout_pulse_end: got %b expected %b", {bagd, err, busy}, 6'b0);
        end
        barq = 4'hf;
        @(negedge clk);
        n_cmp++;
        if ({bagd, gidx} !== {4'b1000, 2'd3}) begin
            n_err++;
            $display("FAIL timeout_ptr_adv: got %b expected %b", {bagd, gidx}, {4'b1000, 2'd3});
        end
        barq = 4'b0;
        @(negedge clk);
    endtask

    task automatic test_abort();
        do_reset();
        barq = 4'b0010;
        @(negedge clk);
        n_cmp++;
        if ({bagd, gidx} !== {4'b0010, 2'd1}) begin
            n_err++;
            $display("FAIL abort_grant: got %b expected %b", {bagd, gidx}, {4'b0010, 2'd1});
        end
        barq = 4'b0;
        av   = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bagd, tr, ds, busy, err} !== 8'b0) begin
            n_err++;
            $display("FAIL abort_idle: got %b expected %b", {bagd, tr, ds, busy, err}, 8'b0);
        end
        av   = 1'b0;
        barq = 4'b0110;
        @(negedge clk);
        n_cmp++;
        if ({bagd, gidx} !== {4'b0100, 2'd2}) begin
            n_err++;
            $display("FAIL abort_ptr_adv: got %b expected %b", {bagd, gidx}, {4'b0100, 2'd2});
        end
        barq = 4'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_strobe();
        do_reset();
        barq = 4'b0001;
        @(negedge clk);
        av = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ds !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_strobe: got %b expected 1", ds);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (obs !== 10'b0) begin
            n_err++;
            $display("FAIL midrst_async: got %b expected %b", obs, 10'b0);
        end
        av = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        barq  = 4'b1001;
        @(negedge clk);
        n_cmp++;
        if (obs !== {4'b0001, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL midrst_resume: got %b expected %b", obs, {4'b0001, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0});
        end
        barq = 4'b0;
        @(negedge clk);
    endtask

`ifdef ARB_ERR_CNT_EN
    task automatic test_err_cnt();
        int pulses = 0;
        int cycles = 0;
        do_reset();
        barq = 4'b0001;
        while (pulses < 300 && cycles < 10000) begin
            @(negedge clk);
            cycles++;
            if (err) pulses++;
        end
        n_cmp++;
        if (pulses !== 300) begin
            n_err++;
            $display("FAIL errcnt_pulses: got %0d expected 300", pulses);
        end
        n_cmp++;
        if (err_cnt !== 8'd255) begin
            n_err++;
            $display("FAIL errcnt_saturate: got %0d expected 255", err_cnt);
        end
        repeat (13) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({err, err_cnt} !== {1'b1, 8'd0}) begin
            n_err++;
            $display("FAIL errcnt_clear_wins: got %b expected %b", {err, err_cnt}, {1'b1, 8'd0});
        end
        err_clr = 1'b0;
        repeat (14) @(negedge clk);
        n_cmp++;
        if ({err, err_cnt} !== {1'b1, 8'd1}) begin
            n_err++;
            $display("FAIL errcnt_restart: got %b expected %b", {err, err_cnt}, {1'b1, 8'd1});
        end
        barq = 4'b0;
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_rr_order();
        test_timeout();
        test_abort();
        test_reset_mid_strobe();
`ifdef ARB_ERR_CNT_EN
        test_err_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
